// File: rtl/stimulus_gen_if.sv
// stimulus_gen_if: run control and operand/status bundle between the generator and its consumer.
interface stimulus_gen_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic             i_hold;
   logic [WIDTH-1:0] o_ia;
   logic [WIDTH-1:0] o_ib;
   logic             o_valid;
   logic             o_busy;
   logic             o_done;
   logic [15:0]      o_count;
   modport master (
      input  i_start, i_hold,
      output o_ia, o_ib, o_valid, o_busy, o_done, o_count
   );
   modport slave (
      output i_start, i_hold,
      input  o_ia, o_ib, o_valid, o_busy, o_done, o_count
   );
endinterface

// File: rtl/stimulus_gen.sv
// stimulus_gen: issues 8 directed operand pairs, then NUM_RANDOM LFSR-generated pairs, all outputs registered.
module stimulus_gen #(
   parameter int               WIDTH      = 32,
   parameter int               NUM_RANDOM = 256,
   parameter logic [WIDTH-1:0] SEED_A     = 32'h0000_0001,
   parameter logic [WIDTH-1:0] SEED_B     = 32'h1234_5679
) (
   input logic             clk,
   input logic             reset,
   stimulus_gen_if.master  bus
);
   typedef enum logic [1:0] {IDLE, DIRECTED, RANDOM, DONE} state_t;
   localparam logic [WIDTH-1:0] TAPS = WIDTH'(32'h8020_0003);
   localparam logic [WIDTH-1:0] SA = (SEED_A == '0) ? WIDTH'(1) : SEED_A;
   localparam logic [WIDTH-1:0] SB = (SEED_B == '0) ? WIDTH'(1) : SEED_B;
   localparam logic [15:0] LAST = 16'(8 + NUM_RANDOM);
   localparam logic [WIDTH-1:0] DA [8] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                          32'h7FFF_FFFF, 32'h8000_0000, 32'hAAAA_AAAA, 32'h1234_5678};
   localparam logic [WIDTH-1:0] DB [8] = '{32'h0, 32'h1, 32'h1, 32'hFFFF_FFFF,
                                          32'h1, 32'h8000_0000, 32'h5555_5555, 32'h8765_4321};
   state_t           state, state_n;
   logic [WIDTH-1:0] la, lb, la_n, lb_n, ia_n, ib_n;
   logic [15:0]      count_n;
   logic             valid_n;
   logic [2:0]       idx;
   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
      return (s >> 1) ^ (s[0] ? TAPS : '0);
   endfunction
   // during DIRECTED the count of vectors already issued is the next table index
   assign idx = bus.o_count[2:0];
   always_comb begin
      state_n = state;
      la_n    = la;
      lb_n    = lb;
      ia_n    = bus.o_ia;
      ib_n    = bus.o_ib;
      count_n = bus.o_count;
      valid_n = 1'b0;
      if ((state == IDLE || state == DONE) && bus.i_start) begin
         state_n = DIRECTED;
         la_n    = SA;
         lb_n    = SB;
         ia_n    = DA[0];
         ib_n    = DB[0];
         count_n = 16'd1;
         valid_n = 1'b1;
      end else if ((state == DIRECTED || state == RANDOM) && !bus.i_hold) begin
         if (state == RANDOM && bus.o_count == LAST) begin
            state_n = DONE;
         end else begin
            valid_n = 1'b1;
            count_n = bus.o_count + 16'd1;
            if (state == DIRECTED && bus.o_count != 16'd8) begin
               ia_n = DA[idx];
               ib_n = DB[idx];
            end else begin
               state_n = RANDOM;
               ia_n    = la;
               ib_n    = lb;
               la_n    = step(la);
               lb_n    = step(lb);
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         la          <= SA;
         lb          <= SB;
         bus.o_ia    <= '0;
         bus.o_ib    <= '0;
         bus.o_valid <= 1'b0;
         bus.o_busy  <= 1'b0;
         bus.o_done  <= 1'b0;
         bus.o_count <= '0;
      end else begin
         state       <= state_n;
         la          <= la_n;
         lb          <= lb_n;
         bus.o_ia    <= ia_n;
         bus.o_ib    <= ib_n;
         bus.o_valid <= valid_n;
         bus.o_busy  <= state_n == DIRECTED || state_n == RANDOM;
         bus.o_done  <= state_n == DONE;
         bus.o_count <= count_n;
      end
   end
endmodule
